// File: rtl/spi_regfile_pkg.sv
// Shared types and constants for the SPI register-file arbiter.
package spi_regfile_pkg;

    localparam logic [15:0] BAD_ADDR_DATA_DEF = 16'hDEAD;
    localparam logic [15:0] ID_VALUE_DEF      = 16'hA5C3;

    typedef enum logic [2:0] {
        IDLE,
        SPI_WR,
        SPI_RD,
        HOST_ACC,
        TX_GO
    } state_t;

    // One latched SPI command.
    typedef struct packed {
        logic        valid;
        logic [7:0]  addr;
        logic [15:0] data;
    } pend_cmd_t;

    // Full 8-bit address compared against the array depth; never truncated.
    function automatic logic addr_in_range(input logic [7:0] addr, input int depth);
        return (int'(addr) < depth);
    endfunction

endpackage

// File: rtl/spi_cmd_latch.sv
// Captures one class of single-cycle SPI command pulse with its address and
// data, holding it until the arbiter clears it. A new pulse always wins over
// a same-cycle clear; a pulse that lands on an uncleared entry reports a loss.
module spi_cmd_latch
    import spi_regfile_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        pulse,
    input  logic [7:0]  addr,
    input  logic [15:0] data,
    input  logic        clear,
    output logic        cmd_valid,
    output logic [7:0]  cmd_addr,
    output logic [15:0] cmd_data,
    output logic        lost
);

    pend_cmd_t cmd_reg;

    // Capture on pulse (overwriting any older command), drop on clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_reg <= '0;
        end else if (pulse) begin
            cmd_reg.valid <= 1'b1;
            cmd_reg.addr  <= addr;
            cmd_reg.data  <= data;
        end else if (clear) begin
            cmd_reg.valid <= 1'b0;
        end
    end

    // The held command is being serviced this cycle when clear is high, so
    // only an unserviced entry counts as lost.
    assign lost      = pulse & cmd_reg.valid & ~clear;
    assign cmd_valid = cmd_reg.valid;
    assign cmd_addr  = cmd_reg.addr;
    assign cmd_data  = cmd_reg.data;

endmodule

// File: rtl/spi_regfile_arbiter.sv
// Arbiter for the 16-bit register file shared by the SPI receive path and a
// local host port. SPI commands are latched and always win arbitration over
// the host; reads prefetch into tx_data and tx requests fire tx_start.
// Optional build macro SPI_REGFILE_ID_EN: address 0 becomes a read-only ID
// word (ID_VALUE) on both ports, writes to it are dropped.
module spi_regfile_arbiter
    import spi_regfile_pkg::*;
#(
    parameter int          DEPTH         = 64,
    parameter logic [15:0] BAD_ADDR_DATA = BAD_ADDR_DATA_DEF,
    parameter logic [15:0] ID_VALUE      = ID_VALUE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  spi_addr,
    input  logic [15:0] spi_data,
    input  logic        spi_read_en,
    input  logic        spi_write_en,
    input  logic        spi_tx_req,
    output logic [15:0] tx_data,
    output logic        tx_start,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [7:0]  host_addr,
    input  logic [15:0] host_wdata,
    output logic        host_grant,
    output logic [15:0] host_rdata,
    output logic        host_rvalid,
    output logic        overrun
);

    localparam int IDX_W  = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CMD_WR = 0;
    localparam int CMD_RD = 1;
    localparam int CMD_TX = 2;

`ifdef SPI_REGFILE_ID_EN
    localparam logic ID_EN = 1'b1;
`else
    localparam logic ID_EN = 1'b0;
`endif

    logic [2:0]  cmd_pulse;
    logic [2:0]  cmd_clear;
    logic [2:0]  cmd_lost;
    logic [2:0]  pend_valid;
    logic [7:0]  pend_addr [3];
    logic [15:0] pend_data [3];

    state_t      state_reg;
    logic [15:0] tx_data_reg;
    logic        tx_start_reg;
    logic        host_grant_reg;
    logic [15:0] host_rdata_reg;
    logic        host_rvalid_reg;
    logic        overrun_reg;

    logic [15:0] mem [DEPTH];
    logic [7:0]  rd_addr;
    logic [15:0] rd_word;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;

    assign cmd_pulse = {spi_tx_req, spi_read_en, spi_write_en};
    assign cmd_clear = {state_reg == TX_GO, state_reg == SPI_RD, state_reg == SPI_WR};

    // One latch per SPI command class.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_latch
            spi_cmd_latch u_latch (
                .clk       (clk),
                .reset     (reset),
                .pulse     (cmd_pulse[gi]),
                .addr      (spi_addr),
                .data      (spi_data),
                .clear     (cmd_clear[gi]),
                .cmd_valid (pend_valid[gi]),
                .cmd_addr  (pend_addr[gi]),
                .cmd_data  (pend_data[gi]),
                .lost      (cmd_lost[gi])
            );
        end
    endgenerate

    // Read data only carries an address and tx requests carry neither.
    logic unused_bits;
    assign unused_bits = ^{pend_addr[CMD_TX], pend_data[CMD_RD], pend_data[CMD_TX]};

    // Single read port: SPI read address while servicing an SPI read, else host.
    always_comb begin
        rd_addr = (state_reg == SPI_RD) ? pend_addr[CMD_RD] : host_addr;
        if (ID_EN && rd_addr == 8'd0) begin
            rd_word = ID_VALUE;
        end else if (addr_in_range(rd_addr, DEPTH)) begin
            rd_word = mem[rd_addr[IDX_W-1:0]];
        end else begin
            rd_word = BAD_ADDR_DATA;
        end
    end

    // Single write port: out-of-range and protected-ID writes are dropped.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (state_reg == SPI_WR) begin
            wr_addr = pend_addr[CMD_WR];
            wr_data = pend_data[CMD_WR];
            wr_en   = 1'b1;
        end else if (state_reg == HOST_ACC && host_we) begin
            wr_addr = host_addr;
            wr_data = host_wdata;
            wr_en   = 1'b1;
        end
        if (!addr_in_range(wr_addr, DEPTH) || (ID_EN && wr_addr == 8'd0)) begin
            wr_en = 1'b0;
        end
    end

    // Register array; reset clears every word and wins over a pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    // Arbitration FSM with registered response outputs. The host is also held
    // off while an SPI pulse is arriving so a same-cycle SPI command wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            tx_data_reg     <= '0;
            tx_start_reg    <= 1'b0;
            host_grant_reg  <= 1'b0;
            host_rdata_reg  <= '0;
            host_rvalid_reg <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            tx_start_reg    <= 1'b0;
            host_grant_reg  <= 1'b0;
            host_rvalid_reg <= 1'b0;
            overrun_reg     <= overrun_reg | (|cmd_lost);
            case (state_reg)
                IDLE: begin
                    if (pend_valid[CMD_WR]) begin
                        state_reg <= SPI_WR;
                    end else if (pend_valid[CMD_RD]) begin
                        state_reg <= SPI_RD;
                    end else if (pend_valid[CMD_TX]) begin
                        state_reg    <= TX_GO;
                        tx_start_reg <= 1'b1;
                    end else if (host_req && !(|cmd_pulse)) begin
                        state_reg      <= HOST_ACC;
                        host_grant_reg <= 1'b1;
                    end
                end
                SPI_WR: begin
                    state_reg <= IDLE;
                end
                SPI_RD: begin
                    tx_data_reg <= rd_word;
                    state_reg   <= IDLE;
                end
                HOST_ACC: begin
                    if (!host_we) begin
                        host_rdata_reg  <= rd_word;
                        host_rvalid_reg <= 1'b1;
                    end
                    state_reg <= IDLE;
                end
                TX_GO: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign tx_data     = tx_data_reg;
    assign tx_start    = tx_start_reg;
    assign host_grant  = host_grant_reg;
    assign host_rdata  = host_rdata_reg;
    assign host_rvalid = host_rvalid_reg;
    assign overrun     = overrun_reg;

endmodule

// File: tb/tb_spi_regfile_arbiter.sv
// Directed bench for spi_regfile_arbiter (DEPTH = 64). Handles both builds of
// the SPI_REGFILE_ID_EN option.
module tb_spi_regfile_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  spi_addr;
    logic [15:0] spi_data;
    logic        spi_read_en;
    logic        spi_write_en;
    logic        spi_tx_req;
    logic [15:0] tx_data;
    logic        tx_start;
    logic        host_req;
    logic        host_we;
    logic [7:0]  host_addr;
    logic [15:0] host_wdata;
    logic        host_grant;
    logic [15:0] host_rdata;
    logic        host_rvalid;
    logic        overrun;

    int checks = 0;
    int errors = 0;

`ifdef SPI_REGFILE_ID_EN
    localparam logic [15:0] EXP_ID_A = 16'hA5C3;
    localparam logic [15:0] EXP_ID_B = 16'hA5C3;
`else
    localparam logic [15:0] EXP_ID_A = 16'h0000;
    localparam logic [15:0] EXP_ID_B = 16'h1357;
`endif

    spi_regfile_arbiter #(.DEPTH(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .spi_addr     (spi_addr),
        .spi_data     (spi_data),
        .spi_read_en  (spi_read_en),
        .spi_write_en (spi_write_en),
        .spi_tx_req   (spi_tx_req),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_grant   (host_grant),
        .host_rdata   (host_rdata),
        .host_rvalid  (host_rvalid),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic spi_write(input logic [7:0] a, input logic [15:0] d);
        spi_addr = a; spi_data = d; spi_write_en = 1'b1;
        step();
        spi_write_en = 1'b0;
        repeat (3) step();
    endtask

    // Read pulse at cycle N; tx_data must hold the word at N+3.
    task automatic spi_read_chk(input logic [7:0] a, input logic [15:0] exp, input string tag);
        spi_addr = a; spi_read_en = 1'b1;
        step();
        spi_read_en = 1'b0;
        repeat (2) step();
        check(tag, tx_data, exp);
        step();
    endtask

    // Uncontended host access: grant at N+1, rvalid/rdata at N+2 for reads.
    task automatic host_acc(input logic we, input logic [7:0] a, input logic [15:0] wd,
                            input logic [15:0] exp, input string tag);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = wd;
        step();
        check({tag, "_grant"}, {15'd0, host_grant}, 16'd1);
        host_req = 1'b0;
        step();
        check({tag, "_grant_pulse"}, {15'd0, host_grant}, 16'd0);
        if (!we) begin
            check({tag, "_rvalid"}, {15'd0, host_rvalid}, 16'd1);
            check({tag, "_rdata"}, host_rdata, exp);
        end else begin
            check({tag, "_no_rvalid"}, {15'd0, host_rvalid}, 16'd0);
        end
        step();
    endtask

    initial begin
        logic got;
        reset = 1'b1;
        spi_addr = '0; spi_data = '0; spi_read_en = 1'b0; spi_write_en = 1'b0; spi_tx_req = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Reset state
        check("rst_tx_data", tx_data, 16'h0000);
        check("rst_tx_start", {15'd0, tx_start}, 16'd0);
        check("rst_host_grant", {15'd0, host_grant}, 16'd0);
        check("rst_host_rvalid", {15'd0, host_rvalid}, 16'd0);
        check("rst_host_rdata", host_rdata, 16'h0000);
        check("rst_overrun", {15'd0, overrun}, 16'd0);
        host_acc(1'b0, 8'h05, 16'h0, 16'h0000, "rst_mem_cleared");

        // SPI write, SPI read with latency, tx_req 20 cycles after the read
        spi_write(8'h05, 16'h1234);
        spi_addr = 8'h05; spi_read_en = 1'b1;
        step();
        spi_read_en = 1'b0;
        step();
        check("rd_lat_n2_old", tx_data, 16'h0000);
        step();
        check("rd_lat_n3_new", tx_data, 16'h1234);
        repeat (17) step();
        spi_tx_req = 1'b1;
        step();
        spi_tx_req = 1'b0;
        check("txs_m1", {15'd0, tx_start}, 16'd0);
        step();
        check("txs_m2", {15'd0, tx_start}, 16'd1);
        check("txs_m2_data", tx_data, 16'h1234);
        step();
        check("txs_m3", {15'd0, tx_start}, 16'd0);
        repeat (2) step();

        // Host write vs SPI write in the same cycle: SPI goes first
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h05; host_wdata = 16'hBEEF;
        spi_write_en = 1'b1; spi_addr = 8'h05; spi_data = 16'h1111;
        step();
        spi_write_en = 1'b0;
        check("contend_host_not_first", {15'd0, host_grant}, 16'd0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (host_grant) got = 1'b1;
        end
        host_req = 1'b0;
        check("contend_grant_seen", {15'd0, got}, 16'd1);
        repeat (2) step();
        host_acc(1'b0, 8'h05, 16'h0, 16'hBEEF, "contend_rd");

        // Out-of-range addresses
        spi_read_chk(8'd200, 16'hDEAD, "bad_rd_200");
        spi_read_chk(8'd64, 16'hDEAD, "bad_rd_64");
        spi_read_chk(8'd63, 16'h0000, "edge_rd_63");
        spi_write(8'd200, 16'h7777);
        spi_read_chk(8'd8, 16'h0000, "bad_wr_alias_8");
        host_acc(1'b0, 8'h05, 16'h0, 16'hBEEF, "bad_wr_keep_5");
        host_acc(1'b0, 8'd200, 16'h0, 16'hDEAD, "host_bad_rd");

        // Two writes on consecutive cycles during a host access -> overrun
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h05;
        step();
        check("ovr_grant", {15'd0, host_grant}, 16'd1);
        host_req = 1'b0;
        spi_write_en = 1'b1; spi_addr = 8'h0A; spi_data = 16'hAAAA;
        step();
        spi_data = 16'hBBBB;
        check("ovr_not_yet", {15'd0, overrun}, 16'd0);
        check("ovr_host_rvalid", {15'd0, host_rvalid}, 16'd1);
        check("ovr_host_rdata", host_rdata, 16'hBEEF);
        step();
        spi_write_en = 1'b0;
        check("ovr_set", {15'd0, overrun}, 16'd1);
        repeat (3) step();
        spi_read_chk(8'h0A, 16'hBBBB, "ovr_second_wins");
        check("ovr_sticky", {15'd0, overrun}, 16'd1);

        // Read and tx_req together: tx_start carries the fresh word
        spi_write(8'h03, 16'h5A5A);
        spi_addr = 8'h03; spi_read_en = 1'b1; spi_tx_req = 1'b1;
        step();
        spi_read_en = 1'b0; spi_tx_req = 1'b0;
        check("rdtx_n1", {15'd0, tx_start}, 16'd0);
        step();
        check("rdtx_n2", {15'd0, tx_start}, 16'd0);
        step();
        check("rdtx_n3", {15'd0, tx_start}, 16'd0);
        check("rdtx_n3_data", tx_data, 16'h5A5A);
        step();
        check("rdtx_n4", {15'd0, tx_start}, 16'd1);
        check("rdtx_n4_data", tx_data, 16'h5A5A);
        step();
        check("rdtx_n5", {15'd0, tx_start}, 16'd0);
        step();

        // Address 0: ID word when the option is built in, plain register otherwise
        host_acc(1'b1, 8'h00, 16'h0000, 16'h0, "id_wr0");
        spi_read_chk(8'h00, EXP_ID_A, "id_spi_rd_a");
        host_acc(1'b1, 8'h00, 16'h1357, 16'h0, "id_wr1");
        spi_read_chk(8'h00, EXP_ID_B, "id_spi_rd_b");
        host_acc(1'b0, 8'h00, 16'h0, EXP_ID_B, "id_host_rd");

        // Reset during a host read: no rvalid, state cleared
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h05;
        step();
        check("rstacc_grant", {15'd0, host_grant}, 16'd1);
        host_req = 1'b0;
        reset = 1'b1;
        step();
        check("rstacc_no_rvalid", {15'd0, host_rvalid}, 16'd0);
        check("rstacc_rdata", host_rdata, 16'h0000);
        step();
        reset = 1'b0;
        step();
        check("rstacc_overrun", {15'd0, overrun}, 16'd0);
        check("rstacc_tx_data", tx_data, 16'h0000);
        host_acc(1'b0, 8'h05, 16'h0, 16'h0000, "rstacc_mem");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
